// File: rtl/marquee_pkg.sv
// ---------------------------------------------------------------------------
// marquee_pkg : shared marquee speed/error codes, observer states, period math
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package marquee_pkg;

  typedef enum logic [1:0] {
    SPEED_2S   = 2'b00,
    SPEED_1S   = 2'b01,
    SPEED_HALF = 2'b10,
    SPEED_QTR  = 2'b11
  } speed_e;

  typedef enum logic [1:0] {
    ERR_NONE         = 2'b00,
    ERR_NOT_ONEHOT   = 2'b01,
    ERR_ILLEGAL_MOVE = 2'b10,
    ERR_STALL        = 2'b11
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ACQUIRE = 2'b01,
    ST_TRACK   = 2'b10
  } obs_state_e;

  // Mode k steps every (2 s >> k): 2*CLK_FREQ, CLK_FREQ, CLK_FREQ/2, CLK_FREQ/4.
  function automatic longint unsigned nominal_period(input longint unsigned clk_freq,
                                                     input logic [1:0]      mode);
    return (clk_freq << 1) >> mode;
  endfunction

  function automatic logic [1:0] onehot_to_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/marquee_observer_if.sv
// ---------------------------------------------------------------------------
// marquee_observer_if : marquee LED bus plus observer decode/status outputs
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface marquee_observer_if;
  logic [3:0] led_in;
  logic [1:0] pos;
  logic       pos_valid;
  logic       dir_up;
  logic       step;
  logic [1:0] speed_code;
  logic       speed_valid;
  logic       err;
  logic [1:0] err_code;
  logic [7:0] err_count;

  // master = marquee/LED driver side, slave = observer
  modport master (
    output led_in,
    input  pos, pos_valid, dir_up, step, speed_code, speed_valid,
           err, err_code, err_count
  );

  modport slave (
    input  led_in,
    output pos, pos_valid, dir_up, step, speed_code, speed_valid,
           err, err_code, err_count
  );
endinterface

`default_nettype wire

// File: rtl/marquee_dwell_timer.sv
// ---------------------------------------------------------------------------
// marquee_dwell_timer : saturating dwell counter, speed-mode match, stall flag
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module marquee_dwell_timer
  import marquee_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 125000000,
  parameter int unsigned TOL_SHIFT = 3,
  parameter int unsigned CNT_W     = 29
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_change,
  output logic       o_match,
  output logic [1:0] o_mode,
  output logic       o_stall
);

  localparam longint unsigned  c_P0        = nominal_period(64'(CLK_FREQ), SPEED_2S);
  localparam logic [CNT_W-1:0] c_STALL_LIM = CNT_W'(c_P0 + (c_P0 >> TOL_SHIFT));
  localparam logic [CNT_W-1:0] c_CNT_MAX   = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_cnt;

  function automatic logic [CNT_W-1:0] lo_bound(input logic [1:0] mode);
    longint unsigned p;
    p = nominal_period(64'(CLK_FREQ), mode);
    return CNT_W'(p - (p >> TOL_SHIFT));
  endfunction

  function automatic logic [CNT_W-1:0] hi_bound(input logic [1:0] mode);
    longint unsigned p;
    p = nominal_period(64'(CLK_FREQ), mode);
    return CNT_W'(p + (p >> TOL_SHIFT));
  endfunction

  // A count of N on a change cycle means the previous pattern was held N cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_change) begin
      r_cnt <= CNT_W'(1);
    end else if (r_cnt != c_CNT_MAX) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    o_match = 1'b0;
    o_mode  = 2'b00;
    for (int k = 0; k < 4; k++) begin
      if ((r_cnt >= lo_bound(2'(k))) && (r_cnt <= hi_bound(2'(k)))) begin
        o_match = 1'b1;
        o_mode  = 2'(k);
      end
    end
  end

  assign o_stall = (r_cnt > c_STALL_LIM);

endmodule

`default_nettype wire

// File: rtl/marquee_observer.sv
// ---------------------------------------------------------------------------
// marquee_observer : passive bounce-marquee LED monitor / speed classifier
// Optional: MARQUEE_OBS_ERRCNT_EN enables the saturating err_count.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module marquee_observer
  import marquee_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 125000000,
  parameter int unsigned TOL_SHIFT = 3,
  parameter int unsigned CNT_W     = 29
) (
  input  logic                clk,
  input  logic                rst,
  marquee_observer_if.slave   bus
);

  obs_state_e r_state, w_state_nxt;
  logic [3:0] r_led_q, r_led_prev;
  logic       r_noh_prev;
  logic [1:0] r_pos, w_pos_nxt;
  logic       r_pos_valid, w_pos_valid_nxt;
  logic       r_dir_up, w_dir_up_nxt;
  logic       r_dir_known, w_dir_known_nxt;
  logic       r_step, w_step_nxt;
  logic [1:0] r_speed_code, w_speed_code_nxt;
  logic       r_speed_valid, w_speed_valid_nxt;
  logic       r_err, w_err_nxt;
  logic [1:0] r_err_code, w_err_code_nxt;

  logic       w_onehot, w_change, w_up, w_adjacent, w_reversal, w_legal;
  logic [1:0] w_idx;
  logic       w_match, w_stall;
  logic [1:0] w_mode;

  assign w_onehot   = $onehot(r_led_q);
  assign w_change   = (r_led_q != r_led_prev);
  assign w_idx      = onehot_to_idx(r_led_q);
  assign w_up       = (w_idx > r_pos);
  assign w_adjacent = ({1'b0, w_idx} == ({1'b0, r_pos} + 3'd1)) ||
                      ({1'b0, r_pos} == ({1'b0, w_idx} + 3'd1));
  // Direction is only trusted after a legal move; ends always force the turn.
  assign w_reversal = r_dir_known && ((r_pos == 2'd1) || (r_pos == 2'd2)) &&
                      (w_up != r_dir_up);
  assign w_legal    = w_adjacent && !w_reversal;

  marquee_dwell_timer #(
    .CLK_FREQ  (CLK_FREQ),
    .TOL_SHIFT (TOL_SHIFT),
    .CNT_W     (CNT_W)
  ) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .i_change (w_change),
    .o_match  (w_match),
    .o_mode   (w_mode),
    .o_stall  (w_stall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_led_q       <= 4'b0000;
      r_led_prev    <= 4'b0000;
      r_noh_prev    <= 1'b1;  // the reset-time 0000 bus is not a fresh violation
      r_pos         <= 2'd0;
      r_pos_valid   <= 1'b0;
      r_dir_up      <= 1'b0;
      r_dir_known   <= 1'b0;
      r_step        <= 1'b0;
      r_speed_code  <= 2'b00;
      r_speed_valid <= 1'b0;
      r_err         <= 1'b0;
      r_err_code    <= 2'b00;
    end else begin
      r_state       <= w_state_nxt;
      r_led_q       <= bus.led_in;
      r_led_prev    <= r_led_q;
      r_noh_prev    <= !w_onehot;
      r_pos         <= w_pos_nxt;
      r_pos_valid   <= w_pos_valid_nxt;
      r_dir_up      <= w_dir_up_nxt;
      r_dir_known   <= w_dir_known_nxt;
      r_step        <= w_step_nxt;
      r_speed_code  <= w_speed_code_nxt;
      r_speed_valid <= w_speed_valid_nxt;
      r_err         <= w_err_nxt;
      r_err_code    <= w_err_code_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_pos_nxt         = r_pos;
    w_pos_valid_nxt   = r_pos_valid;
    w_dir_up_nxt      = r_dir_up;
    w_dir_known_nxt   = r_dir_known;
    w_step_nxt        = 1'b0;
    w_speed_code_nxt  = r_speed_code;
    w_speed_valid_nxt = r_speed_valid;
    w_err_nxt         = 1'b0;
    w_err_code_nxt    = r_err_code;

    if (!w_onehot) begin
      if (!r_noh_prev) begin
        w_err_nxt      = 1'b1;
        w_err_code_nxt = ERR_NOT_ONEHOT;
      end
      w_pos_valid_nxt   = 1'b0;
      w_speed_valid_nxt = 1'b0;
      w_dir_known_nxt   = 1'b0;
      w_state_nxt       = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_pos_nxt       = w_idx;
          w_pos_valid_nxt = 1'b1;
          w_state_nxt     = ST_ACQUIRE;
        end
        ST_ACQUIRE, ST_TRACK: begin
          if (w_change) begin
            w_pos_nxt = w_idx;
            if (w_legal) begin
              w_step_nxt      = 1'b1;
              w_dir_up_nxt    = w_up;
              w_dir_known_nxt = 1'b1;
              w_state_nxt     = ST_TRACK;
              // The first dwell after acquisition is partial and never classified.
              if (r_state == ST_TRACK) begin
                w_speed_valid_nxt = w_match;
                if (w_match) w_speed_code_nxt = w_mode;
              end
            end else begin
              w_err_nxt         = 1'b1;
              w_err_code_nxt    = ERR_ILLEGAL_MOVE;
              w_speed_valid_nxt = 1'b0;
              w_dir_known_nxt   = 1'b0;
              w_state_nxt       = ST_ACQUIRE;
            end
          end else if ((r_state == ST_TRACK) && w_stall) begin
            w_err_nxt         = 1'b1;
            w_err_code_nxt    = ERR_STALL;
            w_speed_valid_nxt = 1'b0;
            w_state_nxt       = ST_ACQUIRE;
          end
        end
        default: begin
          w_pos_valid_nxt   = 1'b0;
          w_speed_valid_nxt = 1'b0;
          w_state_nxt       = ST_IDLE;
        end
      endcase
    end
  end

`ifdef MARQUEE_OBS_ERRCNT_EN
  logic [7:0] r_err_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_count <= 8'd0;
    end else if (w_err_nxt && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign bus.err_count = r_err_count;
`else
  assign bus.err_count = 8'd0;
`endif

  assign bus.pos         = r_pos;
  assign bus.pos_valid   = r_pos_valid;
  assign bus.dir_up      = r_dir_up;
  assign bus.step        = r_step;
  assign bus.speed_code  = r_speed_code;
  assign bus.speed_valid = r_speed_valid;
  assign bus.err         = r_err;
  assign bus.err_code    = r_err_code;

endmodule

`default_nettype wire

// File: tb/tb_marquee_observer.sv
// ---------------------------------------------------------------------------
// tb_marquee_observer : directed + random marquee traffic against a dwell model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_marquee_observer;

  localparam int CLK_FREQ = 400;
  localparam int TOL      = 3;
  localparam int P0       = 2 * CLK_FREQ;
  localparam int STALL    = P0 + (P0 >> TOL);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_pass  = 0;
  bit   cmp_en  = 1'b0;

  marquee_observer_if bus();

  marquee_observer #(
    .CLK_FREQ  (CLK_FREQ),
    .TOL_SHIFT (TOL),
    .CNT_W     (12)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d", n_total);
    $fatal(1);
  end

  // ---------------- behavioural model ----------------
  logic [3:0] m_led = 4'b0000, m_prev = 4'b0000;
  bit         bad_prev = 1'b1, known = 1'b0;
  int         phase = 0;            // 0 no position, 1 acquiring, 2 tracking
  longint     cyc = 0, last_chg = 0, dwell;
  logic [1:0] e_pos = '0, e_code = '0, e_ecode = '0;
  logic       e_pv = 0, e_dir = 0, e_step = 0, e_sv = 0, e_err = 0;
  logic [7:0] e_ecnt = '0;
  int         np, dlt, kk;
  bit         legal, chg;

  function automatic int idx_of(input logic [3:0] v);
    int r = 0;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic int classify(input longint d);
    int r = -1;
    for (int k = 0; k < 4; k++) begin
      longint p = longint'(P0 >> k);
      longint t = p >> TOL;
      if (d >= p - t && d <= p + t) r = k;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_led = 0; m_prev = 0; bad_prev = 1; known = 0; phase = 0;
      cyc = 0; last_chg = 0;
      e_pos = 0; e_code = 0; e_ecode = 0; e_pv = 0; e_dir = 0;
      e_step = 0; e_sv = 0; e_err = 0; e_ecnt = 0;
    end else begin
      e_step = 0; e_err = 0;
      chg   = (m_led != m_prev);
      dwell = cyc - last_chg;
      if (!$onehot(m_led)) begin
        if (!bad_prev) begin e_err = 1; e_ecode = 2'b01; end
        e_pv = 0; e_sv = 0; known = 0; phase = 0;
      end else if (phase == 0) begin
        e_pos = 2'(idx_of(m_led)); e_pv = 1; phase = 1;
      end else if (chg) begin
        np    = idx_of(m_led);
        dlt   = np - int'(e_pos);
        legal = (dlt == 1 || dlt == -1);
        if (legal && known && (e_pos == 1 || e_pos == 2) && ((dlt > 0) != e_dir)) legal = 0;
        e_pos = 2'(np);
        if (legal) begin
          e_step = 1; e_dir = (dlt > 0); known = 1;
          if (phase == 2) begin
            kk = classify(dwell);
            if (kk >= 0) begin e_code = 2'(kk); e_sv = 1; end
            else e_sv = 0;
          end
          phase = 2;
        end else begin
          e_err = 1; e_ecode = 2'b10; e_sv = 0; known = 0; phase = 1;
        end
      end else if (phase == 2 && dwell > STALL) begin
        e_err = 1; e_ecode = 2'b11; e_sv = 0; phase = 1;
      end
`ifdef MARQUEE_OBS_ERRCNT_EN
      if (e_err && e_ecnt != 8'hFF) e_ecnt = e_ecnt + 8'd1;
`endif
      bad_prev = !$onehot(m_led);
      if (chg) last_chg = cyc;
      m_prev = m_led;
      m_led  = bus.led_in;
      cyc++;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h t=%0t", name, got, exp, $time);
  endtask

  logic [18:0] act_vec, exp_vec;
  always @(negedge clk) begin
    if (cmp_en) begin
      act_vec = {bus.pos, bus.pos_valid, bus.dir_up, bus.step, bus.speed_code,
                 bus.speed_valid, bus.err, bus.err_code, bus.err_count};
      exp_vec = {e_pos, e_pv, e_dir, e_step, e_code, e_sv, e_err, e_ecode, e_ecnt};
      chk("cycle_outputs{pos,pv,dir,step,code,sv,err,ecode,ecnt}",
          32'(act_vec), 32'(exp_vec));
    end
  end

  task automatic hold(input logic [3:0] pat, input int n);
    bus.led_in = pat;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pos"},   32'(bus.pos), 0);
    chk({tag, "_pv"},    32'(bus.pos_valid), 0);
    chk({tag, "_dir"},   32'(bus.dir_up), 0);
    chk({tag, "_step"},  32'(bus.step), 0);
    chk({tag, "_code"},  32'(bus.speed_code), 0);
    chk({tag, "_sv"},    32'(bus.speed_valid), 0);
    chk({tag, "_err"},   32'(bus.err), 0);
    chk({tag, "_ecode"}, 32'(bus.err_code), 0);
    chk({tag, "_ecnt"},  32'(bus.err_count), 0);
  endtask

  function automatic int rand_period();
    int k, p, t;
    if ($urandom_range(0, 99) < 3) return int'($urandom_range(STALL + 1, STALL + 40));
    k = int'($urandom_range(0, 3));
    p = P0 >> k;
    t = p >> TOL;
    return p + int'($urandom_range(0, 2 * t + 4)) - t - 2;
  endfunction

  logic [3:0] bads [5] = '{4'b0000, 4'b0011, 4'b0101, 4'b1111, 4'b1100};
  logic [3:0] pat;

  initial begin
    int p;
    bit d;
    int r;
    bus.led_in = 4'b0001;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    cmp_en = 1'b1;
    rst    = 1'b0;

    // normal 2 s marquee and the bounce at index 3
    hold(4'b0001, 50); hold(4'b0010, 800); hold(4'b0100, 800);
    chk("up_pos", 32'(bus.pos), 2);   chk("up_dir", 32'(bus.dir_up), 1);
    chk("up_sv", 32'(bus.speed_valid), 1); chk("up_code", 32'(bus.speed_code), 0);
    hold(4'b1000, 800); hold(4'b0100, 800);
    chk("down_pos", 32'(bus.pos), 2); chk("down_dir", 32'(bus.dir_up), 0);
    chk("no_err_code", 32'(bus.err_code), 0);

    // 0.25 s speed, off-nominal dwell, then back on nominal
    hold(4'b0010, 100); hold(4'b0001, 100);
    chk("fast_code", 32'(bus.speed_code), 3); chk("fast_sv", 32'(bus.speed_valid), 1);
    hold(4'b0010, 130); hold(4'b0100, 105);
    chk("off_sv", 32'(bus.speed_valid), 0); chk("off_code", 32'(bus.speed_code), 3);
    chk("off_err", 32'(bus.err_code), 0);
    hold(4'b1000, 50);
    chk("back_sv", 32'(bus.speed_valid), 1);

    // tolerance edges: 112 in, 113 out, 88 in
    hold(4'b0100, 112); hold(4'b0010, 113);
    chk("edge112_sv", 32'(bus.speed_valid), 1);
    hold(4'b0001, 88);
    chk("edge113_sv", 32'(bus.speed_valid), 0);
    hold(4'b0010, 50);
    chk("edge88_sv", 32'(bus.speed_valid), 1);

    // illegal jump 0 -> 2
    hold(4'b0100, 100); hold(4'b1000, 100); hold(4'b0100, 100);
    hold(4'b0010, 100); hold(4'b0001, 100); hold(4'b0100, 100);
    chk("jump_ecode", 32'(bus.err_code), 2); chk("jump_pos", 32'(bus.pos), 2);
    chk("jump_sv", 32'(bus.speed_valid), 0);
    hold(4'b1000, 100);
    chk("acq_sv", 32'(bus.speed_valid), 0);  chk("acq_pos", 32'(bus.pos), 3);
    hold(4'b0100, 100);
    chk("retrack_sv", 32'(bus.speed_valid), 1);

    // not one-hot, then re-acquire
    hold(4'b0011, 5);
    chk("noh_pv", 32'(bus.pos_valid), 0); chk("noh_ecode", 32'(bus.err_code), 1);
    hold(4'b0001, 50);
    chk("reacq_pv", 32'(bus.pos_valid), 1); chk("reacq_pos", 32'(bus.pos), 0);

    // mid-range reversal
    hold(4'b0010, 100); hold(4'b0100, 100); hold(4'b0010, 100);
    chk("rev_ecode", 32'(bus.err_code), 2); chk("rev_pos", 32'(bus.pos), 1);

    // stall
    hold(4'b0001, 100); hold(4'b0010, 905);
    chk("stall_ecode", 32'(bus.err_code), 3);
`ifdef MARQUEE_OBS_ERRCNT_EN
    chk("stall_ecnt", 32'(bus.err_count), 4);
`endif

    // asynchronous reset mid-dwell
    hold(4'b0100, 300);
    #2 rst = 1'b1;
    #1 chk_all_zero("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // random traffic with occasional faults
    p = 0; d = 1'b1;
    for (int s = 0; s < 70; s++) begin
      r = int'($urandom_range(0, 99));
      if (r < 5) begin
        hold(bads[$urandom_range(0, 4)], int'($urandom_range(1, 4)));
      end else if (r < 10) begin
        p = (p + 2) % 4;
      end else if (r < 14 && (p == 1 || p == 2)) begin
        d = !d;
        p = d ? p + 1 : p - 1;
      end else begin
        if (p == 3) d = 1'b0;
        else if (p == 0) d = 1'b1;
        p = d ? p + 1 : p - 1;
      end
      pat = 4'b0001 << p;
      hold(pat, rand_period());
    end
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
